// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: per-state datapath controls,
// illegal-instruction pulse and retired-instruction counter.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [3:0]  ALU_control,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t cur, nxt;

    logic op_lw, op_sw, op_r, op_beq, op_bne, op_j, op_addi;
    logic pc_w, mem_w, ir_w, reg_w, ill;
    logic retire;

    assign op_lw   = (opcode == 6'b100011);
    assign op_sw   = (opcode == 6'b101011);
    assign op_r    = (opcode == 6'b000000);
    assign op_beq  = (opcode == 6'b000100);
    assign op_bne  = (opcode == 6'b000101);
    assign op_j    = (opcode == 6'b000010);
    assign op_addi = (opcode == 6'b001000);

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Every terminal state returns to FETCH, so leaving one retires.
    always_comb begin
        unique case (cur)
            MEMWB, MEMWR, ALUWB,
            BRANCH, JUMP, ADDIWB: retire = ~reset;
            default:              retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       instr_count <= 32'd0;
        else if (retire) instr_count <= instr_count + 32'd1;
    end

    always_comb begin
        nxt         = FETCH;
        ALU_control = 4'b0010;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        pc_w        = 1'b0;
        mem_w       = 1'b0;
        ir_w        = 1'b0;
        reg_w       = 1'b0;
        ill         = 1'b0;
        unique case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                ALUSrcB = 2'b01;
                nxt     = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                unique case (1'b1)
                    op_lw, op_sw:   nxt = MEMADR;
                    op_r:           nxt = EXEC;
                    op_beq, op_bne: nxt = BRANCH;
                    op_j:           nxt = JUMP;
                    op_addi:        nxt = ADDIEX;
                    default: begin
                        nxt = FETCH;
                        ill = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = op_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = MEMWB;
            end
            MEMWB: begin
                reg_w    = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                mem_w = 1'b1;
                IorD  = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                nxt     = ALUWB;
                case (funct)
                    6'b100000: ALU_control = 4'b0010;
                    6'b100010: ALU_control = 4'b0110;
                    6'b100100: ALU_control = 4'b0000;
                    6'b100101: ALU_control = 4'b0001;
                    6'b101010: ALU_control = 4'b0111;
                    default:   ill = 1'b1;
                endcase
            end
            ALUWB: begin
                reg_w  = 1'b1;
                RegDst = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_control = 4'b0110;
                PCSource    = 2'b01;
                pc_w        = (op_beq & zero) | (op_bne & ~zero);
            end
            JUMP: begin
                pc_w     = 1'b1;
                PCSource = 2'b10;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: reg_w = 1'b1;
            default: nxt = FETCH;
        endcase
    end

    // Write enables and the illegal pulse are suppressed during reset.
    assign PCWrite  = pc_w  & ~reset;
    assign MemWrite = mem_w & ~reset;
    assign IRWrite  = ir_w  & ~reset;
    assign RegWrite = reg_w & ~reset;
    assign illegal  = ill   & ~reset;
    assign state    = cur;

endmodule
